uut_1_chk: RTL and testbench
============================

// Module: uut_1_chk
// PURPOSE
//   Downstream result checker for the uut_1 FCS datapath (bytep -> bitp).
//   Consumes the per-frame res/exp/obs/val result of the bit-parallel
//   stage, grades each frame, and keeps run counters plus a capture of the
//   first failing frame. A run covers a programmed number of frames and
//   ends with a single pass/fail verdict.
// PARAMETERS
//   RESIDUE  32'hC704DD7B  good-frame CRC-32 residue expected on res_i
//   CW       16            width of frame/error counters and frame index
// PORTS
//   bclk_i      in   1    clock; same clock that produces val_i
//   rst_i       in   1    reset, synchronous, active-high
//   start_i     in   1    1-cycle pulse: begin a run
//   nframes_i   in   CW   frames in the run; sampled on accepted start_i
//   res_i       in   32   CRC residue over frame incl. FCS
//   exp_i       in   32   FCS computed over payload
//   obs_i       in   32   FCS observed in frame
//   val_i       in   1    1-cycle pulse: res/exp/obs valid for one frame
//   busy_o      out  1    run in progress
//   done_o      out  1    run complete; held until next start or reset
//   pass_o      out  1    valid with done_o: 1 = zero failing frames
//   frm_cnt_o   out  CW   frames graded in current/last run
//   err_cnt_o   out  CW   failing frames, saturates at all-ones
//   err_idx_o   out  CW   0-based index of first failing frame
//   err_res_o   out  32   res_i of first failing frame
//   err_exp_o   out  32   exp_i of first failing frame
//   err_obs_o   out  32   obs_i of first failing frame
// BEHAVIOUR
//   - Reset: state IDLE; every output 0; abandons any run mid-operation,
//     including a frame held in the compare stage.
//   - Frame fails if (res_i != RESIDUE) or (exp_i != obs_i).
//   - Pipeline: cycle 0 val_i sampled; cycle 1 compare stage registers
//     inputs + fail flag; cycle 2 counters/capture/state visible on outputs.
//   - FSM states IDLE, RUN, DONE:
//     IDLE: val_i ignored; start_i -> RUN, clear counters and capture regs,
//       latch nframes_i. If nframes_i == 0 -> DONE next cycle, pass_o=1.
//     RUN: busy_o=1. Graded frame: frm_cnt+1; on fail err_cnt+1 (saturate);
//       first fail only (err_cnt was 0): load err_idx=frm_cnt (pre-incr),
//       err_res/exp/obs. When frm_cnt reaches nframes -> DONE in same update.
//       start_i ignored in RUN.
//     DONE: busy_o=0, done_o=1, pass_o=(err_cnt==0); outputs frozen; val_i
//       ignored; start_i -> RUN with fresh clear (as from IDLE).
//   - Boundaries: val_i in same cycle as accepted start_i is not graded;
//     val_i on cycle after start_i is frame 0. Frames arriving after the
//     last counted frame are dropped, never counted. err_cnt stops at
//     all-ones; frm_cnt never exceeds nframes so never wraps.
//   - Back-to-back val_i (every cycle) supported at full rate.
// STRUCTURE
//   - Shared package uut_1_pkg: state enum (IDLE/RUN/DONE), RESIDUE
//     constant, default CW.
//   - One sub-module uut_1_chk_cmp: cycle-1 register stage holding
//     res/exp/obs, valid and fail flag; cleared by rst_i and by start.
//   - Top: FSM, counters, first-fail capture, output drive.
// TESTING
//   - Reset mid-run after 3 of 5 frames -> all outputs 0, state IDLE,
//     later val_i pulses leave frm_cnt_o at 0.
//   - start nframes=4, 4 good frames (res=C704DD7B, exp=obs) -> done_o 2
//     cycles after 4th val_i, pass_o=1, frm_cnt_o=4, err_cnt_o=0.
//   - start nframes=5, frame 2 res=0, frame 4 exp!=obs -> pass_o=0,
//     err_cnt_o=2, err_idx_o=2, err_res_o=0000_0000.
//   - start nframes=0 -> done_o=1, pass_o=1, frm_cnt_o=0 one cycle later.
//   - val_i same cycle as start, then 3 val_i back-to-back with
//     nframes=2 -> frm_cnt_o=2, third frame dropped.
//   - CW=4, 20 bad frames, nframes=15 -> err_cnt_o=4'hF, done after 15th.

Source files
------------

// File: rtl/uut_1_pkg.sv
// Shared types and constants for the uut_1 FCS result checker.
package uut_1_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic [31:0] RESIDUE_C  = 32'hC704DD7B;
   localparam int          CW_DEFAULT = 16;

   function automatic logic frame_fails(input logic [31:0] res,
                                        input logic [31:0] exp_fcs,
                                        input logic [31:0] obs,
                                        input logic [31:0] residue);
      return (res != residue) || (exp_fcs != obs);
   endfunction

endpackage

// File: rtl/uut_1_chk_cmp.sv
// Compare stage: registers one frame's res/exp/obs together with its fail flag.
module uut_1_chk_cmp
   import uut_1_pkg::*;
#(
   parameter logic [31:0] RESIDUE = RESIDUE_C
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        clr_i,
   input  logic        en_i,
   input  logic        val_i,
   input  logic [31:0] res_i,
   input  logic [31:0] exp_i,
   input  logic [31:0] obs_i,
   output logic        vld_o,
   output logic        fail_o,
   output logic [31:0] res_o,
   output logic [31:0] exp_o,
   output logic [31:0] obs_o
);

   logic        vld_d, vld_q;
   logic        fail_d, fail_q;
   logic [31:0] res_d, res_q;
   logic [31:0] exp_d, exp_q;
   logic [31:0] obs_d, obs_q;

   always_comb begin
      vld_d  = 1'b0;
      fail_d = fail_q;
      res_d  = res_q;
      exp_d  = exp_q;
      obs_d  = obs_q;
      if (clr_i) begin
         fail_d = 1'b0;
         res_d  = '0;
         exp_d  = '0;
         obs_d  = '0;
      end else if (val_i && en_i) begin
         vld_d  = 1'b1;
         fail_d = frame_fails(res_i, exp_i, obs_i, RESIDUE);
         res_d  = res_i;
         exp_d  = exp_i;
         obs_d  = obs_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vld_q  <= 1'b0;
         fail_q <= 1'b0;
         res_q  <= '0;
         exp_q  <= '0;
         obs_q  <= '0;
      end else begin
         vld_q  <= vld_d;
         fail_q <= fail_d;
         res_q  <= res_d;
         exp_q  <= exp_d;
         obs_q  <= obs_d;
      end
   end

   assign vld_o  = vld_q;
   assign fail_o = fail_q;
   assign res_o  = res_q;
   assign exp_o  = exp_q;
   assign obs_o  = obs_q;

endmodule

// File: rtl/uut_1_chk.sv
// Run-level FCS result checker: grades frames, counts failures, captures the first failing frame.
module uut_1_chk
   import uut_1_pkg::*;
#(
   parameter logic [31:0] RESIDUE = RESIDUE_C,
   parameter int          CW      = CW_DEFAULT
) (
   input  logic          bclk_i,
   input  logic          rst_i,
   input  logic          start_i,
   input  logic [CW-1:0] nframes_i,
   input  logic [31:0]   res_i,
   input  logic [31:0]   exp_i,
   input  logic [31:0]   obs_i,
   input  logic          val_i,
   output logic          busy_o,
   output logic          done_o,
   output logic          pass_o,
   output logic [CW-1:0] frm_cnt_o,
   output logic [CW-1:0] err_cnt_o,
   output logic [CW-1:0] err_idx_o,
   output logic [31:0]   err_res_o,
   output logic [31:0]   err_exp_o,
   output logic [31:0]   err_obs_o,
   output logic [1:0]    dbg_state_o
);

   localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

   state_e        state_d, state_q;
   logic [CW-1:0] nframes_d, nframes_q;
   logic [CW-1:0] frm_cnt_d, frm_cnt_q;
   logic [CW-1:0] err_cnt_d, err_cnt_q;
   logic [CW-1:0] err_idx_d, err_idx_q;
   logic [31:0]   err_res_d, err_res_q;
   logic [31:0]   err_exp_d, err_exp_q;
   logic [31:0]   err_obs_d, err_obs_q;

   logic          start_acc;
   logic          cmp_vld, cmp_fail;
   logic [31:0]   cmp_res, cmp_exp, cmp_obs;

   // start_i is only honoured outside a run; the same pulse flushes the compare stage.
   assign start_acc = start_i && (state_q != ST_RUN);

   uut_1_chk_cmp #(.RESIDUE(RESIDUE)) u_cmp (
      .clk_i  (bclk_i),
      .rst_i  (rst_i),
      .clr_i  (start_acc),
      .en_i   (state_q == ST_RUN),
      .val_i  (val_i),
      .res_i  (res_i),
      .exp_i  (exp_i),
      .obs_i  (obs_i),
      .vld_o  (cmp_vld),
      .fail_o (cmp_fail),
      .res_o  (cmp_res),
      .exp_o  (cmp_exp),
      .obs_o  (cmp_obs)
   );

   always_comb begin
      state_d   = state_q;
      nframes_d = nframes_q;
      frm_cnt_d = frm_cnt_q;
      err_cnt_d = err_cnt_q;
      err_idx_d = err_idx_q;
      err_res_d = err_res_q;
      err_exp_d = err_exp_q;
      err_obs_d = err_obs_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_i) begin
               state_d   = (nframes_i == '0) ? ST_DONE : ST_RUN;
               nframes_d = nframes_i;
               frm_cnt_d = '0;
               err_cnt_d = '0;
               err_idx_d = '0;
               err_res_d = '0;
               err_exp_d = '0;
               err_obs_d = '0;
            end
         end
         ST_RUN: begin
            if (cmp_vld) begin
               frm_cnt_d = frm_cnt_q + ONE;
               if (cmp_fail) begin
                  if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ONE;
                  // Capture only the first failing frame of the run.
                  if (err_cnt_q == '0) begin
                     err_idx_d = frm_cnt_q;
                     err_res_d = cmp_res;
                     err_exp_d = cmp_exp;
                     err_obs_d = cmp_obs;
                  end
               end
               if (frm_cnt_d == nframes_q) state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge bclk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         nframes_q <= '0;
         frm_cnt_q <= '0;
         err_cnt_q <= '0;
         err_idx_q <= '0;
         err_res_q <= '0;
         err_exp_q <= '0;
         err_obs_q <= '0;
      end else begin
         state_q   <= state_d;
         nframes_q <= nframes_d;
         frm_cnt_q <= frm_cnt_d;
         err_cnt_q <= err_cnt_d;
         err_idx_q <= err_idx_d;
         err_res_q <= err_res_d;
         err_exp_q <= err_exp_d;
         err_obs_q <= err_obs_d;
      end
   end

   assign busy_o      = (state_q == ST_RUN);
   assign done_o      = (state_q == ST_DONE);
   assign pass_o      = (state_q == ST_DONE) && (err_cnt_q == '0);
   assign frm_cnt_o   = frm_cnt_q;
   assign err_cnt_o   = err_cnt_q;
   assign err_idx_o   = err_idx_q;
   assign err_res_o   = err_res_q;
   assign err_exp_o   = err_exp_q;
   assign err_obs_o   = err_obs_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uut_1_chk.sv
// Bench for uut_1_chk: run verdicts scoreboarded against a frame-list reference model.
module tb_uut_1_chk;

   localparam logic [31:0] RES_GOOD = 32'hC704DD7B;

   typedef struct {
      logic        pass;
      int          frm;
      int          err;
      int          idx;
      logic [31:0] r;
      logic [31:0] e;
      logic [31:0] o;
   } res_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        start4 = 1'b0;
   logic        val = 1'b0;
   logic [15:0] nf = '0;
   logic [3:0]  nf4 = '0;
   logic [31:0] d_res = '0, d_exp = '0, d_obs = '0;

   logic        busy, done, pass;
   logic [15:0] frm, errc, eidx;
   logic [31:0] eres, eexp, eobs;
   logic [1:0]  st;

   logic        busy4, done4, pass4;
   logic [3:0]  frm4, errc4, eidx4;
   logic [31:0] eres4, eexp4, eobs4;
   logic [1:0]  st4;

   int   n_cmp = 0;
   int   n_fail = 0;
   res_t exp_q[$];
   res_t exp4_q[$];
   logic [31:0] fr_res[$], fr_exp[$], fr_obs[$];
   bit   armed = 0, armed4 = 0;

   always #5 clk = ~clk;

   uut_1_chk u_dut (
      .bclk_i(clk), .rst_i(rst), .start_i(start), .nframes_i(nf),
      .res_i(d_res), .exp_i(d_exp), .obs_i(d_obs), .val_i(val),
      .busy_o(busy), .done_o(done), .pass_o(pass),
      .frm_cnt_o(frm), .err_cnt_o(errc), .err_idx_o(eidx),
      .err_res_o(eres), .err_exp_o(eexp), .err_obs_o(eobs),
      .dbg_state_o(st)
   );

   uut_1_chk #(.CW(4)) u_dut4 (
      .bclk_i(clk), .rst_i(rst), .start_i(start4), .nframes_i(nf4),
      .res_i(d_res), .exp_i(d_exp), .obs_i(d_obs), .val_i(val),
      .busy_o(busy4), .done_o(done4), .pass_o(pass4),
      .frm_cnt_o(frm4), .err_cnt_o(errc4), .err_idx_o(eidx4),
      .err_res_o(eres4), .err_exp_o(eexp4), .err_obs_o(eobs4),
      .dbg_state_o(st4)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
      end
   endtask

   task automatic check_run(input string tag, input res_t e, input logic p, input logic b,
                            input logic [31:0] f, input logic [31:0] ec, input logic [31:0] ix,
                            input logic [31:0] r, input logic [31:0] ex, input logic [31:0] o);
      check({tag, "_pass"}, {31'b0, p}, {31'b0, e.pass});
      check({tag, "_busy"}, {31'b0, b}, 32'd0);
      check({tag, "_frm"}, f, e.frm);
      check({tag, "_err"}, ec, e.err);
      check({tag, "_idx"}, ix, e.idx);
      check({tag, "_res"}, r, e.r);
      check({tag, "_exp"}, ex, e.e);
      check({tag, "_obs"}, o, e.o);
   endtask

   // Reference: grade the first n frames of the list in arrival order.
   function automatic res_t model(input int n, input int cw);
      res_t m;
      int   maxc = (1 << cw) - 1;
      m = '{pass: 1'b1, frm: 0, err: 0, idx: 0, r: 32'd0, e: 32'd0, o: 32'd0};
      for (int i = 0; i < n; i++) begin
         m.frm = m.frm + 1;
         if (fr_res[i] != RES_GOOD || fr_exp[i] != fr_obs[i]) begin
            if (m.err == 0) begin
               m.idx = i;
               m.r = fr_res[i];
               m.e = fr_exp[i];
               m.o = fr_obs[i];
            end
            if (m.err < maxc) m.err = m.err + 1;
         end
      end
      m.pass = (m.err == 0);
      return m;
   endfunction

   task automatic add_frame(input logic [31:0] r, input logic [31:0] e, input logic [31:0] o);
      fr_res.push_back(r);
      fr_exp.push_back(e);
      fr_obs.push_back(o);
   endtask

   task automatic add_random_frame(input int bad_pct);
      logic [31:0] e = $urandom;
      if ($urandom_range(99, 0) < bad_pct) begin
         if ($urandom_range(1, 0) == 1) add_frame(RES_GOOD ^ ($urandom | 32'd1), e, e);
         else add_frame(RES_GOOD, e, e ^ ($urandom | 32'd1));
      end else begin
         add_frame(RES_GOOD, e, e);
      end
   endtask

   // Drive one run from the frame list: start pulse, frames with optional gaps, then wait for the verdict.
   task automatic do_run(input bit sel, input int n, input bit val_at_start, input int gap_max,
                         input bit chk_lat);
      res_t e;
      int   cw = sel ? 4 : 16;
      int   gaps;
      e = model(n, cw);
      if (sel) exp4_q.push_back(e);
      else exp_q.push_back(e);
      @(posedge clk); #1;
      if (sel) begin start4 = 1'b1; nf4 = n[3:0]; end
      else begin start = 1'b1; nf = n[15:0]; end
      val = val_at_start;
      d_res = 32'd0; d_exp = $urandom; d_obs = ~d_exp;
      for (int i = 0; i < fr_res.size(); i++) begin
         @(posedge clk); #1;
         start = 1'b0; start4 = 1'b0;
         val = 1'b1; d_res = fr_res[i]; d_exp = fr_exp[i]; d_obs = fr_obs[i];
         gaps = $urandom_range(gap_max, 0);
         repeat (gaps) begin
            @(posedge clk); #1;
            val = 1'b0;
         end
      end
      @(posedge clk); #1;
      start = 1'b0; start4 = 1'b0; val = 1'b0;
      if (chk_lat) begin
         @(negedge clk);
         check("lat_done_early", {31'b0, done}, 32'd0);
         @(negedge clk);
         check("lat_done_on_time", {31'b0, done}, 32'd1);
      end
      if (n == 0 && !sel) begin
         @(negedge clk);
         check("zero_done", {31'b0, done}, 32'd1);
         check("zero_frm", {16'b0, frm}, 32'd0);
      end
      for (int k = 0; k < 80 && (sel ? exp4_q.size() : exp_q.size()) != 0; k++) @(negedge clk);
      if ((sel ? exp4_q.size() : exp_q.size()) != 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL run_timeout: done not seen, n=%0d sel=%0d", n, sel);
         exp_q.delete();
         exp4_q.delete();
      end
      fr_res.delete(); fr_exp.delete(); fr_obs.delete();
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_busy"}, {31'b0, busy}, 32'd0);
      check({tag, "_done"}, {31'b0, done}, 32'd0);
      check({tag, "_pass"}, {31'b0, pass}, 32'd0);
      check({tag, "_frm"}, {16'b0, frm}, 32'd0);
      check({tag, "_err"}, {16'b0, errc}, 32'd0);
      check({tag, "_idx"}, {16'b0, eidx}, 32'd0);
      check({tag, "_res"}, eres, 32'd0);
      check({tag, "_exp"}, eexp, 32'd0);
      check({tag, "_obs"}, eobs, 32'd0);
      check({tag, "_state"}, {30'b0, st}, 32'd0);
   endtask

   // Monitors: arm on an accepted start, pop the expected verdict when done is presented.
   always @(negedge clk) begin
      if (rst) begin
         armed = 0;
      end else begin
         if (armed && done) begin
            armed = 0;
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_done: frm %0d", frm);
            end else begin
               check_run("run16", exp_q.pop_front(), pass, busy, {16'b0, frm}, {16'b0, errc},
                         {16'b0, eidx}, eres, eexp, eobs);
            end
         end
         if (start && !busy) armed = 1;
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         armed4 = 0;
      end else begin
         if (armed4 && done4) begin
            armed4 = 0;
            if (exp4_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_done4: frm %0d", frm4);
            end else begin
               check_run("run4", exp4_q.pop_front(), pass4, busy4, {28'b0, frm4}, {28'b0, errc4},
                         {28'b0, eidx4}, eres4, eexp4, eobs4);
            end
         end
         if (start4 && !busy4) armed4 = 1;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_zero("reset");

      // Reset in the middle of a 5-frame run, with frame 2 still in the compare stage.
      @(posedge clk); #1 start = 1'b1; nf = 16'd5;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         start = 1'b0; val = 1'b1; d_res = RES_GOOD; d_exp = i; d_obs = i;
      end
      @(posedge clk); #1 val = 1'b0; rst = 1'b1;
      @(negedge clk);
      check("pre_rst_frm", {16'b0, frm}, 32'd2);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check_zero("mid_rst");
      @(posedge clk); #1 val = 1'b1;
      @(posedge clk); #1 val = 1'b1;
      @(posedge clk); #1 val = 1'b0;
      repeat (3) @(negedge clk);
      check("post_rst_frm", {16'b0, frm}, 32'd0);
      check("post_rst_state", {30'b0, st}, 32'd0);

      // Four good frames back to back, done exactly two cycles after the last.
      for (int i = 0; i < 4; i++) add_frame(RES_GOOD, 32'h1000 + i, 32'h1000 + i);
      do_run(0, 4, 0, 0, 1);

      // Frame 2 bad residue, frame 4 FCS mismatch.
      add_frame(RES_GOOD, 32'hA, 32'hA);
      add_frame(RES_GOOD, 32'hB, 32'hB);
      add_frame(32'h0, 32'hC, 32'hC);
      add_frame(RES_GOOD, 32'hD, 32'hD);
      add_frame(RES_GOOD, 32'hE, 32'hF);
      do_run(0, 5, 0, 1, 0);

      do_run(0, 0, 0, 0, 0);

      // val with start is not graded; third frame after the run is full is dropped.
      for (int i = 0; i < 3; i++) add_frame(RES_GOOD, 32'h55 + i, 32'h55 + i);
      fr_res[2] = 32'hDEAD_BEEF;
      do_run(0, 2, 1, 0, 0);

      // Narrow counters: error count saturates at all-ones, run ends after frame 15.
      for (int i = 0; i < 20; i++) add_frame(32'h1234_0000 + i, 32'h77, 32'h77);
      do_run(1, 15, 0, 0, 0);

      for (int it = 0; it < 8; it++) begin
         int n = $urandom_range(8, 1);
         int extra = $urandom_range(2, 0);
         for (int i = 0; i < n + extra; i++) add_random_frame(30);
         do_run(0, n, $urandom_range(1, 0), 2, 0);
      end

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
